// File: rtl/mode_counter_if.sv
// Bus bundle for mode_counter: control/config in, count and flags out.
// COUNTER_PWM_EN adds the pwm signal to the bundle.
interface mode_counter_if #(
    parameter int unsigned BITS          = 8,
    parameter int unsigned PRESCALE_BITS = 4
);
    logic                     enable;
    logic [1:0]               mode;
    logic [PRESCALE_BITS-1:0] prescale;
    logic                     load;
    logic [BITS-1:0]          load_value;
    logic [BITS-1:0]          compare;
    logic [BITS-1:0]          count;
    logic                     wrap;
    logic                     match;
    logic                     done;
`ifdef COUNTER_PWM_EN
    logic                     pwm;

    modport master (
        output enable, mode, prescale, load, load_value, compare,
        input  count, wrap, match, done, pwm
    );
    modport slave (
        input  enable, mode, prescale, load, load_value, compare,
        output count, wrap, match, done, pwm
    );
`else
    modport master (
        output enable, mode, prescale, load, load_value, compare,
        input  count, wrap, match, done
    );
    modport slave (
        input  enable, mode, prescale, load, load_value, compare,
        output count, wrap, match, done
    );
`endif
endinterface

// File: rtl/mode_counter.sv
// Prescaled BITS-wide counter with up/down/one-shot/triangle modes, load, compare match.
// Optional registered PWM output enabled by defining COUNTER_PWM_EN.
module mode_counter #(
    parameter int unsigned BITS          = 8,
    parameter int unsigned PRESCALE_BITS = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    mode_counter_if.slave bus
);

    localparam logic [1:0] MODE_UP      = 2'b00;
    localparam logic [1:0] MODE_DOWN    = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;
    localparam logic [1:0] MODE_TRI     = 2'b11;

    localparam logic [BITS-1:0]          CNT_ZERO = '0;
    localparam logic [BITS-1:0]          CNT_ONE  = BITS'(1);
    localparam logic [BITS-1:0]          CNT_MAX  = '1;
    localparam logic [PRESCALE_BITS-1:0] PSC_ONE  = PRESCALE_BITS'(1);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [PRESCALE_BITS-1:0] r_psc;
    logic [BITS-1:0]          r_count;
    dir_t                     r_dir;
    logic                     r_done;
    logic                     r_wrap;
    logic                     r_match;

    logic [PRESCALE_BITS-1:0] w_psc_nxt;
    logic [BITS-1:0]          w_count_nxt;
    dir_t                     w_dir_nxt;
    logic                     w_done_nxt;
    logic                     w_wrap_nxt;
    logic                     w_match_nxt;
    logic                     w_tick;
    logic                     w_upd;

    // State register; reset is synchronous and discards any pending tick.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_psc   <= '0;
            r_count <= CNT_ZERO;
            r_dir   <= DIR_UP;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
            r_match <= 1'b0;
        end else begin
            r_psc   <= w_psc_nxt;
            r_count <= w_count_nxt;
            r_dir   <= w_dir_nxt;
            r_done  <= w_done_nxt;
            r_wrap  <= w_wrap_nxt;
            r_match <= w_match_nxt;
        end
    end

    // Next-state: load beats tick beats hold; >= keeps a lowered prescale from stalling.
    always_comb begin
        w_tick      = bus.enable && (r_psc >= bus.prescale);
        w_psc_nxt   = r_psc;
        w_count_nxt = r_count;
        w_dir_nxt   = r_dir;
        w_done_nxt  = r_done;
        w_wrap_nxt  = 1'b0;
        w_upd       = 1'b0;

        if (bus.load) begin
            w_count_nxt = bus.load_value;
            w_psc_nxt   = '0;
            w_dir_nxt   = DIR_UP;
            w_done_nxt  = 1'b0;
        end else begin
            if (bus.enable) begin
                w_psc_nxt = w_tick ? '0 : r_psc + PSC_ONE;
            end
            if (w_tick) begin
                case (bus.mode)
                    MODE_UP: begin
                        w_count_nxt = r_count + CNT_ONE;
                        w_wrap_nxt  = (r_count == CNT_MAX);
                        w_upd       = 1'b1;
                    end
                    MODE_DOWN: begin
                        w_count_nxt = r_count - CNT_ONE;
                        w_wrap_nxt  = (r_count == CNT_ZERO);
                        w_upd       = 1'b1;
                    end
                    MODE_ONESHOT: begin
                        if (r_count == CNT_MAX) begin
                            w_done_nxt = 1'b1;
                        end else begin
                            w_count_nxt = r_count + CNT_ONE;
                            w_done_nxt  = r_done | (w_count_nxt == CNT_MAX);
                            w_upd       = 1'b1;
                        end
                    end
                    MODE_TRI: begin
                        w_upd = 1'b1;
                        if (r_dir == DIR_UP) begin
                            if (r_count == CNT_MAX) begin
                                w_count_nxt = CNT_MAX - CNT_ONE;
                                w_dir_nxt   = DIR_DOWN;
                                w_wrap_nxt  = 1'b1;
                            end else begin
                                w_count_nxt = r_count + CNT_ONE;
                            end
                        end else begin
                            if (r_count == CNT_ZERO) begin
                                w_count_nxt = CNT_ONE;
                                w_dir_nxt   = DIR_UP;
                                w_wrap_nxt  = 1'b1;
                            end else begin
                                w_count_nxt = r_count - CNT_ONE;
                            end
                        end
                    end
                endcase
            end
        end

        // Match only when a tick actually moves count onto compare.
        w_match_nxt = w_upd && (w_count_nxt == bus.compare);
    end

    assign bus.count = r_count;
    assign bus.wrap  = r_wrap;
    assign bus.match = r_match;
    assign bus.done  = r_done;

`ifdef COUNTER_PWM_EN
    logic r_pwm;

    // PWM tracks the count being written this edge, so it lines up with count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= (w_count_nxt < bus.compare);
        end
    end

    assign bus.pwm = r_pwm;
`endif

endmodule
